fix_to_float_batch: RTL and testbench
=====================================

Name: fix_to_float_batch

Overview:
- Parametrised, multi-operand successor to the Program 1 fixed-to-float converter.
- On `start`, reads `num_ops` signed fixed-point operands from byte-wide data memory and converts each to a binary float (sign/exponent/mantissa).
- Writes each result back to memory, then raises `done`.
- Adds what the earlier block lacked: selectable rounding (truncate or round-to-nearest-even), inexact/overflow flags, and batch addressing.

Parameters:
- `IN_W`, 16: operand width in bits; must be 8, 16, 24 or 32.
- `FRAC_W`, 8: number of fraction bits in the operand.
- `EXP_W`, 5: float exponent width; bias is 2^(EXP_W-1)-1.
- `MAN_W`, 10: float stored-mantissa width; 1+EXP_W+MAN_W must be a multiple of 8.
- `ADDR_W`, 8: memory address width.
- Elaboration check: bias-FRAC_W >= 1, so no subnormal results are possible.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin batch; sampled only while idle
- `rnd_mode`  in  1  0 = truncate, 1 = round-nearest-even; latched at start
- `num_ops`  in  8  operand count; latched at start
- `src_base`  in  ADDR_W  first operand byte address; latched at start
- `dst_base`  in  ADDR_W  first result byte address; latched at start
- `mem_addr`  out  ADDR_W  memory address
- `mem_rd_en`  out  1  read strobe; data returns next cycle
- `mem_rd_data`  in  8  read data
- `mem_wr_en`  out  1  write strobe
- `mem_wr_data`  out  8  write data
- `busy`  out  1  batch in progress
- `done`  out  1  batch complete; held until next accepted start
- `inexact`  out  1  sticky: any result was rounded or truncated
- `overflow`  out  1  sticky: any result saturated to infinity

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, latched config is cleared. Reset mid-batch aborts immediately; no further memory accesses follow.
- Start acceptance:
  - `start` in IDLE latches the config and clears `done`, `inexact` and `overflow`.
  - `start` while `busy` is ignored.
  - `num_ops`=0 sets `done` one cycle after start with no memory accesses.
- Memory layout:
  - Little-endian. Operand k occupies bytes src_base+k*IN_B .. +IN_B-1, with IN_B = IN_W/8.
  - Result k occupies dst_base+k*OUT_B .., with OUT_B = (1+EXP_W+MAN_W)/8.
  - Addresses wrap modulo 2^ADDR_W.
- FSM states and cycle cost per operand:
  - IDLE: waits for `start`.
  - READ: IN_B read cycles plus 1 capture cycle.
  - CLASSIFY (1 cycle): sign = operand MSB; magnitude = |operand|, held in IN_W unsigned, so the most negative value gives 2^(IN_W-1) exactly. A zero operand goes straight to WRITE.
  - NORM: one left shift per cycle until the magnitude MSB is 1. Takes IN_W-1-p cycles, where p is the leading-one position; a decrementing counter tracks p.
  - ROUND (1 cycle).
  - WRITE: OUT_B cycles, one byte per cycle.
  - NEXT: if operands remain, go to READ; otherwise set `done`, clear `busy`, return to IDLE.
- Exact latency from start to `done` = 1 + sum over operands of (IN_B+1 + 1 + shifts + 1 + OUT_B). Zero operands skip NORM and ROUND.
- Arithmetic:
  - Biased exponent = p - FRAC_W + bias.
  - Mantissa = the MAN_W bits below the leading one. G = the next bit; S = OR of all remaining bits.
  - Truncate mode: drop G and S.
  - RNE mode: increment the mantissa if G & (S | mantissa LSB). A mantissa carry-out zeroes the mantissa and increments the exponent.
  - `inexact` is set if G|S is nonzero, in either mode.
  - If the final exponent is >= 2^EXP_W-1: output ±infinity (exponent all ones, mantissa 0) and set `overflow`.
- Zero input gives +0 (all zero bits).
- `mem_rd_en` and `mem_wr_en` are never asserted in the same cycle. `mem_wr_data` is valid only with `mem_wr_en`.

Decomposition:
- Package `fxfl_pkg` holds:
  - the state enum (IDLE, READ, CLASSIFY, NORM, ROUND, WRITE, NEXT);
  - the `rnd_mode` encoding constants;
  - bias and byte-count functions of the parameters.
- Sub-module `fxfl_round`: combinational mantissa/exponent rounder with G/S, mode input, inexact and overflow outputs. It is instantiated once, in the ROUND datapath.

Test Plan:
- Defaults, RNE, num_ops=1, operand 0x0100 -> result 0x3C00; inexact=0; done after 1+3+1+7+1+2 = 15 cycles.
- Defaults, operand 0x8000 (most negative) -> result 0xD800 (sign 1, exponent 22, mantissa 0); inexact=0.
- Defaults, operand 0x7FFF -> truncate gives 0x57FF, RNE gives 0x5800 (exponent carry); inexact=1 in both runs.
- Defaults, RNE ties: 0x0801 -> 0x4800 (stays even); 0x0803 -> 0x4802 (rounds up); zero operand 0x0000 -> 0x0000 with no NORM cycles.
- IN_W=32, FRAC_W=0, num_ops=3, src_base=0xFC (address wrap), operands 0x00010000, 1, -1 -> results 0x7C00 with overflow=1, then 0x3C00, then 0xBC00.
- Reset asserted in NORM of operand 2 of 4 -> outputs 0 immediately, no further writes. A start mid-batch is ignored. num_ops=0 -> done one cycle after start with no memory accesses.

Source files
------------

// File: rtl/fxfl_pkg.sv
// Shared definitions for the batch fixed-to-float converter: FSM states,
// rounding-mode encoding and parameter-derived helper functions.
package fxfl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CLASSIFY,
        NORM,
        ROUND,
        WRITE,
        NEXT
    } state_t;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int unsigned in_bytes(input int unsigned in_w);
        return in_w / 8;
    endfunction

    function automatic int unsigned out_bytes(input int unsigned exp_w, input int unsigned man_w);
        return (1 + exp_w + man_w) / 8;
    endfunction

endpackage

// File: rtl/fxfl_round.sv
// Combinational rounder: applies truncate or round-nearest-even to a mantissa,
// propagates the carry into the exponent and saturates to infinity on overflow.
module fxfl_round
    import fxfl_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [MAN_W-1:0] mant_in,
    input  logic [31:0]      exp_in,
    input  logic             g,
    input  logic             s,
    input  logic             rnd_mode,
    output logic [MAN_W-1:0] mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             inexact,
    output logic             overflow
);

    localparam logic [31:0] EXP_MAX = 32'((1 << EXP_W) - 1);

    logic           inc;
    logic [MAN_W:0] mant_sum;
    logic [31:0]    exp_r;

    always_comb begin
        inc      = (rnd_mode == RND_RNE) && g && (s || mant_in[0]);
        mant_sum = {1'b0, mant_in} + {{MAN_W{1'b0}}, inc};
        exp_r    = exp_in + {31'd0, mant_sum[MAN_W]};
        inexact  = g | s;
        overflow = (exp_r >= EXP_MAX);
        if (overflow) begin
            mant_out = '0;
            exp_out  = '1;
        end else begin
            mant_out = mant_sum[MAN_W-1:0];
            exp_out  = exp_r[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/fix_to_float_batch.sv
// Batch converter: reads signed fixed-point operands from byte-wide memory,
// normalises one bit per cycle, rounds, and writes floats back little-endian.
module fix_to_float_batch
    import fxfl_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned MAN_W  = 10,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rnd_mode,
    input  logic [7:0]        num_ops,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              inexact,
    output logic              overflow
);

    localparam int unsigned OUT_W = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS  = exp_bias(EXP_W);
    localparam int unsigned EXT_W = IN_W + MAN_W + 1;
    localparam int unsigned PW    = $clog2(IN_W);

    localparam logic [3:0]    IN_B_C   = 4'(in_bytes(IN_W));
    localparam logic [3:0]    OUT_B_M1 = 4'(out_bytes(EXP_W, MAN_W) - 1);
    localparam logic [PW-1:0] P_MAX    = PW'(IN_W - 1);
    localparam logic [31:0]   EXP_OFF  = 32'(BIAS - FRAC_W);

    if (!(IN_W == 8 || IN_W == 16 || IN_W == 24 || IN_W == 32)) begin : g_bad_in_w
        $error("IN_W must be 8, 16, 24 or 32");
    end
    if ((OUT_W % 8) != 0) begin : g_bad_out_w
        $error("1+EXP_W+MAN_W must be a multiple of 8");
    end
    if (BIAS < FRAC_W + 1) begin : g_bad_bias
        $error("bias-FRAC_W must be at least 1");
    end

    state_t            state_q;
    logic              rnd_q;
    logic [7:0]        ops_left_q;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [3:0]        byte_cnt_q;
    logic [IN_W-1:0]   opnd_q;
    // Bits below the leading-one position; the leading one itself is implicit.
    logic [IN_W-2:0]   mag_q;
    logic [PW-1:0]     p_q;
    logic              sign_q;
    logic [OUT_W-1:0]  result_q;
    logic              done_q;
    logic              inexact_q;
    logic              overflow_q;

    logic [IN_W-1:0]   mag_abs;
    logic [IN_W+7:0]   opnd_shift;
    logic [EXT_W-1:0]  ext;
    logic [MAN_W-1:0]  r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_inexact;
    logic              r_overflow;
    logic [OUT_W-1:0]  res_sh;

    always_comb begin
        mag_abs    = opnd_q[IN_W-1] ? (~opnd_q + 1'b1) : opnd_q;
        opnd_shift = {mem_rd_data, opnd_q} >> 8;
        ext        = {mag_q, {(MAN_W + 2){1'b0}}};
        res_sh     = result_q >> {byte_cnt_q, 3'b000};
    end

    fxfl_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .mant_in  (ext[EXT_W-1 -: MAN_W]),
        .exp_in   (32'(p_q) + EXP_OFF),
        .g        (ext[EXT_W-1-MAN_W]),
        .s        (|ext[EXT_W-2-MAN_W:0]),
        .rnd_mode (rnd_q),
        .mant_out (r_mant),
        .exp_out  (r_exp),
        .inexact  (r_inexact),
        .overflow (r_overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rnd_q      <= 1'b0;
            ops_left_q <= '0;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            byte_cnt_q <= '0;
            opnd_q     <= '0;
            mag_q      <= '0;
            p_q        <= '0;
            sign_q     <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rnd_q      <= rnd_mode;
                        ops_left_q <= num_ops;
                        src_ptr_q  <= src_base;
                        dst_ptr_q  <= dst_base;
                        byte_cnt_q <= '0;
                        done_q     <= 1'b0;
                        inexact_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= (num_ops == 8'd0) ? NEXT : READ;
                    end
                end
                READ: begin
                    // Read data lags the strobe by one cycle; bytes shift in from the top.
                    if (byte_cnt_q != 4'd0) begin
                        opnd_q <= opnd_shift[IN_W-1:0];
                    end
                    if (byte_cnt_q == IN_B_C) begin
                        byte_cnt_q <= '0;
                        state_q    <= CLASSIFY;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        src_ptr_q  <= src_ptr_q + 1'b1;
                    end
                end
                CLASSIFY: begin
                    sign_q <= opnd_q[IN_W-1];
                    mag_q  <= mag_abs[IN_W-2:0];
                    p_q    <= P_MAX;
                    if (mag_abs == '0) begin
                        result_q <= '0;
                        state_q  <= WRITE;
                    end else if (mag_abs[IN_W-1]) begin
                        state_q <= ROUND;
                    end else begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    mag_q <= {mag_q[IN_W-3:0], 1'b0};
                    p_q   <= p_q - 1'b1;
                    if (mag_q[IN_W-2]) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q   <= {sign_q, r_exp, r_mant};
                    inexact_q  <= inexact_q | r_inexact;
                    overflow_q <= overflow_q | r_overflow;
                    state_q    <= WRITE;
                end
                WRITE: begin
                    dst_ptr_q <= dst_ptr_q + 1'b1;
                    if (byte_cnt_q == OUT_B_M1) begin
                        byte_cnt_q <= '0;
                        ops_left_q <= ops_left_q - 8'd1;
                        state_q    <= (ops_left_q == 8'd1) ? NEXT : READ;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                    end
                end
                NEXT: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd_en   = (state_q == READ) && (byte_cnt_q != IN_B_C);
        mem_wr_en   = (state_q == WRITE);
        mem_addr    = mem_rd_en ? src_ptr_q : (mem_wr_en ? dst_ptr_q : '0);
        mem_wr_data = mem_wr_en ? res_sh[7:0] : 8'd0;
        busy        = (state_q != IDLE);
        done        = done_q;
        inexact     = inexact_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_fix_to_float_batch.sv
// Scoreboard bench: a 16-bit default instance and a 32-bit integer instance,
// each checked against an arithmetic float reference model.
module tb_fix_to_float_batch;

    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start16 = 1'b0, start32 = 1'b0, rnd_mode = 1'b0;
    logic [7:0] num_ops = 8'd0, src_base = 8'd0, dst_base = 8'd0;

    logic [7:0] addr16, wdata16, rdata16, addr32, wdata32, rdata32;
    logic       rd16, wr16, busy16, done16, inex16, ovf16;
    logic       rd32, wr32, busy32, done32, inex32, ovf32;

    logic [7:0] mem16 [256];
    logic [7:0] mem32 [256];
    logic [15:0] exp16_q [$];
    logic [15:0] exp32_q [$];
    int reads16 = 0, reads32 = 0;
    int n_checks = 0, n_errors = 0;
    longint ops [8];

    fix_to_float_batch u_dut16 (
        .clk (clk), .reset (reset), .start (start16), .rnd_mode (rnd_mode),
        .num_ops (num_ops), .src_base (src_base), .dst_base (dst_base),
        .mem_addr (addr16), .mem_rd_en (rd16), .mem_rd_data (rdata16),
        .mem_wr_en (wr16), .mem_wr_data (wdata16), .busy (busy16), .done (done16),
        .inexact (inex16), .overflow (ovf16)
    );

    fix_to_float_batch #(.IN_W (32), .FRAC_W (0)) u_dut32 (
        .clk (clk), .reset (reset), .start (start32), .rnd_mode (rnd_mode),
        .num_ops (num_ops), .src_base (src_base), .dst_base (dst_base),
        .mem_addr (addr32), .mem_rd_en (rd32), .mem_rd_data (rdata32),
        .mem_wr_en (wr32), .mem_wr_data (wdata32), .busy (busy32), .done (done32),
        .inexact (inex32), .overflow (ovf32)
    );

    always @(posedge clk) begin
        if (rd16) begin rdata16 <= mem16[addr16]; reads16 <= reads16 + 1; end
        if (rd32) begin rdata32 <= mem32[addr32]; reads32 <= reads32 + 1; end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (wr16) begin
            check("rd_during_wr16", longint'(rd16), 0);
            if (exp16_q.size() == 0) begin
                check("unexpected_write16_addr", longint'(addr16), -1);
            end else begin
                e = exp16_q.pop_front();
                check("wr_addr16", longint'(addr16), longint'(e[15:8]));
                check("wr_data16", longint'(wdata16), longint'(e[7:0]));
            end
        end
        if (wr32) begin
            check("rd_during_wr32", longint'(rd32), 0);
            if (exp32_q.size() == 0) begin
                check("unexpected_write32_addr", longint'(addr32), -1);
            end else begin
                e = exp32_q.pop_front();
                check("wr_addr32", longint'(addr32), longint'(e[15:8]));
                check("wr_data32", longint'(wdata32), longint'(e[7:0]));
            end
        end
    end

    // Value = v / 2^frac_w; result is sign, biased exponent, MAN_W fraction bits.
    task automatic model(input longint v, input int frac_w, input logic rm,
                         output logic [15:0] res, output logic inx, output logic ovf,
                         output int p);
        longint mag, frac_part, rem, half, m;
        int e, sh;
        logic s;
        s = (v < 0);
        mag = s ? -v : v;
        inx = 1'b0;
        ovf = 1'b0;
        p = -1;
        res = 16'h0000;
        if (mag == 0) return;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = p - frac_w + BIAS;
        frac_part = mag - (longint'(1) << p);
        sh = p - MAN_W;
        if (sh > 0) begin
            m = frac_part >> sh;
            rem = frac_part - (m << sh);
            half = longint'(1) << (sh - 1);
        end else begin
            m = frac_part << (-sh);
            rem = 0;
            half = 0;
        end
        inx = (rem != 0);
        if (rm && rem != 0 && (rem > half || (rem == half && m[0]))) m++;
        if (m == (longint'(1) << MAN_W)) begin
            m = 0;
            e++;
        end
        if (e >= 31) begin
            ovf = 1'b1;
            e = 31;
            m = 0;
        end
        res = {s, e[4:0], m[9:0]};
    endtask

    task automatic run(input bit wide, input logic rm, input int n,
                       input logic [7:0] sb, input logic [7:0] db);
        int in_b, in_w, frac, lat, got, p, rd0;
        logic [15:0] r;
        logic ix, ov, acc_ix, acc_ov;
        in_b = wide ? 4 : 2;
        in_w = wide ? 32 : 16;
        frac = wide ? 0 : 8;
        lat = 1;
        acc_ix = 1'b0;
        acc_ov = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < in_b; b++) begin
                if (wide) mem32[8'(int'(sb) + k * in_b + b)] = 8'(ops[k] >> (8 * b));
                else      mem16[8'(int'(sb) + k * in_b + b)] = 8'(ops[k] >> (8 * b));
            end
            model(ops[k], frac, rm, r, ix, ov, p);
            acc_ix |= ix;
            acc_ov |= ov;
            for (int b = 0; b < 2; b++) begin
                if (wide) exp32_q.push_back({8'(int'(db) + 2 * k + b), r[8*b +: 8]});
                else      exp16_q.push_back({8'(int'(db) + 2 * k + b), r[8*b +: 8]});
            end
            lat += (p < 0) ? (in_b + 1 + 1 + 2) : (in_b + 1 + 1 + (in_w - 1 - p) + 1 + 2);
        end
        rd0 = wide ? reads32 : reads16;
        @(negedge clk);
        rnd_mode = rm;
        num_ops = 8'(n);
        src_base = sb;
        dst_base = db;
        if (wide) start32 = 1'b1; else start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start32 = 1'b0;
        check("done_cleared", longint'(wide ? done32 : done16), 0);
        check("busy_after_start", longint'(wide ? busy32 : busy16), 1);
        got = 0;
        for (int c = 1; c <= 4000; c++) begin
            @(posedge clk);
            #1;
            if (wide ? done32 : done16) begin
                got = c;
                break;
            end
        end
        check("latency", longint'(got), longint'(lat));
        check("busy_at_done", longint'(wide ? busy32 : busy16), 0);
        check("inexact", longint'(wide ? inex32 : inex16), longint'(acc_ix));
        check("overflow", longint'(wide ? ovf32 : ovf16), longint'(acc_ov));
        check("pending_writes", longint'(wide ? exp32_q.size() : exp16_q.size()), 0);
        check("read_count", longint'((wide ? reads32 : reads16) - rd0), longint'(n * in_b));
    endtask

    initial begin
        logic [15:0] r;
        logic ix, ov;
        logic signed [15:0] t;
        int p, rd_at_reset;

        #12;
        check("rst_busy", longint'(busy16), 0);
        check("rst_done", longint'(done16), 0);
        check("rst_inexact", longint'(inex16), 0);
        check("rst_overflow", longint'(ovf16), 0);
        check("rst_rd_en", longint'(rd16), 0);
        check("rst_wr_en", longint'(wr16), 0);
        check("rst_addr", longint'(addr16), 0);
        check("rst_wdata", longint'(wdata16), 0);
        @(negedge clk);
        reset = 1'b0;

        ops[0] = 64'sh0100;
        run(1'b0, 1'b1, 1, 8'h10, 8'h80);
        ops[0] = -32768;
        run(1'b0, 1'b1, 1, 8'h20, 8'h90);
        ops[0] = 64'sh7FFF;
        run(1'b0, 1'b0, 1, 8'h30, 8'hA0);
        run(1'b0, 1'b1, 1, 8'h30, 8'hA0);
        ops[0] = 64'sh0801;
        ops[1] = 64'sh0803;
        ops[2] = 0;
        run(1'b0, 1'b1, 3, 8'h40, 8'hB0);
        run(1'b0, 1'b1, 0, 8'h50, 8'hC0);

        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 5))
                    0: ops[k] = 0;
                    1: ops[k] = -32768;
                    2: ops[k] = longint'($urandom_range(1, 255));
                    3: ops[k] = 64'sh7FFF;
                    default: begin
                        t = 16'($urandom);
                        ops[k] = longint'(t);
                    end
                endcase
            end
            run(1'b0, 1'($urandom), n, 8'($urandom), 8'($urandom));
        end

        ops[0] = 64'sh10000;
        ops[1] = 1;
        ops[2] = -1;
        run(1'b1, 1'b1, 3, 8'hFC, 8'h40);

        // Four-operand batch: foreign start mid-batch, then reset in NORM of operand 2.
        for (int k = 0; k < 4; k++) begin
            ops[k] = 1;
            mem16[8'(8'h60 + 2 * k)] = 8'h01;
            mem16[8'(8'h61 + 2 * k)] = 8'h00;
        end
        model(1, 8, 1'b0, r, ix, ov, p);
        exp16_q.push_back({8'hD0, r[7:0]});
        exp16_q.push_back({8'hD1, r[15:8]});
        @(negedge clk);
        rnd_mode = 1'b0;
        num_ops = 8'd4;
        src_base = 8'h60;
        dst_base = 8'hD0;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            if (c == 8) begin
                num_ops = 8'd1;
                src_base = 8'h00;
                dst_base = 8'h00;
                start16 = 1'b1;
            end else begin
                start16 = 1'b0;
            end
        end
        reset = 1'b1;
        #1;
        rd_at_reset = reads16;
        check("abort_busy", longint'(busy16), 0);
        check("abort_rd_en", longint'(rd16), 0);
        check("abort_wr_en", longint'(wr16), 0);
        check("abort_addr", longint'(addr16), 0);
        check("abort_done", longint'(done16), 0);
        check("abort_pending", longint'(exp16_q.size()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_reads", longint'(reads16 - rd_at_reset), 0);
        check("abort_idle_busy", longint'(busy16), 0);
        check("abort_idle_done", longint'(done16), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
